decimation_scheduler: RTL and testbench

// - Shares one decimated output stream between N_CH input channels.
// - Each channel is decimated by its own run-time ratio.
// - Kept samples are arbitrated round-robin onto a single valid/ready output

---
 rtl/decimation_scheduler_pkg.sv | 12 +
 rtl/decimation_scheduler_rr_arbiter.sv | 38 +++
 rtl/decimation_scheduler.sv | 106 ++++++++++
 tb/tb_decimation_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decimation_scheduler_pkg.sv
// Shared widths and types for the decimation scheduler.
// Default channel/ratio geometry; the top derives its own widths from its parameters.
package decimation_scheduler_pkg;
  localparam int DATA_W    = 16;
  localparam int N_CH      = 4;
  localparam int MAX_DECIM = 16;
  localparam int R_W       = $clog2(MAX_DECIM + 1);
  localparam int CH_W      = $clog2(N_CH);

  typedef logic [R_W-1:0]  ratio_t;
  typedef logic [CH_W-1:0] ch_id_t;
endpackage

// File: rtl/decimation_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// The pointer moves past the winner only when the consumer advances.
module rr_arbiter #(
  parameter  int nr_of_req_p = 4,
  localparam int IW = (nr_of_req_p > 1) ? $clog2(nr_of_req_p) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [nr_of_req_p-1:0] req,
  input  logic                   advance,
  output logic [IW-1:0]          grant_id,
  output logic                   grant_valid
);
  logic [IW-1:0] ptr_q, ptr_d;
  int            idx;

  always_comb begin
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = 0;
    // Walk backwards so the nearest requester after ptr_q is written last.
    for (int k = nr_of_req_p - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % nr_of_req_p;
      if (req[idx]) begin
        grant_id    = IW'(idx);
        grant_valid = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (advance && grant_valid)
      ptr_d = (grant_id == IW'(nr_of_req_p - 1)) ? '0 : grant_id + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/decimation_scheduler.sv
// Per-channel run-time decimation into 1-deep hold registers, merged round-robin
// onto one back-pressured valid/ready stream tagged with the source channel.
module decimation_scheduler
  import decimation_scheduler_pkg::*;
#(
  parameter  int data_width_p = DATA_W,
  parameter  int nr_of_ch_p   = N_CH,
  parameter  int max_decim_p  = MAX_DECIM,
  localparam int DW = data_width_p,
  localparam int NC = nr_of_ch_p,
  localparam int RW = $clog2(max_decim_p + 1),
  localparam int CW = $clog2(nr_of_ch_p)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [RW-1:0]  cfg_ratio,
  input  logic [NC-1:0]  x_valid,
  output logic [NC-1:0]  x_ready,
  input  logic [NC*DW-1:0] x,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [DW-1:0]  y,
  output logic [CW-1:0]  y_ch
);
  logic [NC-1:0]          hold_v_q, hold_v_d;
  logic [NC-1:0][DW-1:0]  hold_d_q, hold_d_d;
  logic [NC-1:0][RW-1:0]  cnt_q, cnt_d;
  logic [NC-1:0][RW-1:0]  ratio_q, ratio_d;
  logic                   y_valid_q, y_valid_d;
  logic [DW-1:0]          y_q, y_d;
  logic [CW-1:0]          y_ch_q, y_ch_d;
  logic [CW-1:0]          grant_id;
  logic                   grant_valid;
  logic                   load;

  assign load    = !y_valid_q || y_ready;
  assign x_ready = ~hold_v_q;

  rr_arbiter #(.nr_of_req_p(NC)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (hold_v_q),
    .advance     (load),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  for (genvar i = 0; i < NC; i++) begin : g_ch
    logic cfg_hit, xfer, keep, clr;
    assign cfg_hit = cfg_valid && (cfg_ch == CW'(i));
    assign xfer    = x_valid[i] && !hold_v_q[i];
    assign keep    = xfer && (cnt_q[i] == '0);
    assign clr     = load && grant_valid && (grant_id == CW'(i));

    // A hold can only be filled while empty and only be granted while full,
    // so keep and clr never collide.
    assign hold_v_d[i] = keep || (hold_v_q[i] && !clr);
    assign hold_d_d[i] = keep ? x[i*DW +: DW] : hold_d_q[i];
    assign ratio_d[i]  = !cfg_hit              ? ratio_q[i] :
                         (cfg_ratio == '0)     ? RW'(1)     : cfg_ratio;
    // Transfer is judged on the old count; a coincident cfg write restarts it.
    assign cnt_d[i]    = cfg_hit                              ? '0 :
                         !xfer                                ? cnt_q[i] :
                         (cnt_q[i] == ratio_q[i] - RW'(1))    ? '0 :
                                                                cnt_q[i] + RW'(1);
  end

  always_comb begin
    y_valid_d = y_valid_q;
    y_d       = y_q;
    y_ch_d    = y_ch_q;
    if (load) begin
      y_valid_d = grant_valid;
      if (grant_valid) begin
        y_d    = hold_d_q[grant_id];
        y_ch_d = grant_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q  <= '0;
      hold_d_q  <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < NC; i++) ratio_q[i] <= RW'(1);
      y_valid_q <= 1'b0;
      y_q       <= '0;
      y_ch_q    <= '0;
    end else begin
      hold_v_q  <= hold_v_d;
      hold_d_q  <= hold_d_d;
      cnt_q     <= cnt_d;
      ratio_q   <= ratio_d;
      y_valid_q <= y_valid_d;
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
    end
  end

  assign y_valid = y_valid_q;
  assign y       = y_q;
  assign y_ch    = y_ch_q;
endmodule

// File: tb/tb_decimation_scheduler.sv
// Bench for decimation_scheduler: directed tables/sequences plus random traffic,
// all outputs scored against a per-channel sample-index model.
module tb_decimation_scheduler;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int RW = 5;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_valid;
  logic [CW-1:0]   cfg_ch;
  logic [RW-1:0]   cfg_ratio;
  logic [N-1:0]    x_valid, x_ready;
  logic [N*DW-1:0] x;
  logic            y_valid, y_ready;
  logic [DW-1:0]   y;
  logic [CW-1:0]   y_ch;

  decimation_scheduler dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_ratio(cfg_ratio),
    .x_valid(x_valid), .x_ready(x_ready), .x(x),
    .y_valid(y_valid), .y_ready(y_ready), .y(y), .y_ch(y_ch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[N][$];
  int ratio_m[N];
  int idx_m[N];
  int got_q[$];
  int low_run[N];
  int max_low;

  typedef struct {
    int xv; int xd; int exp_rdy; int exp_yv; int exp_y;
  } t1_vec_t;
  t1_vec_t t1[7];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: sample n (counted since reset/cfg) on a channel is kept iff n % M == 0.
  task automatic tick();
    logic          hv;
    logic [DW-1:0] hy;
    logic [CW-1:0] hch;
    hv  = y_valid && !y_ready && !rst;
    hy  = y;
    hch = y_ch;
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        exp_q[c].delete();
        ratio_m[c] = 1;
        idx_m[c]   = 0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        if (x_valid[c] && x_ready[c]) begin
          if (idx_m[c] % ratio_m[c] == 0) exp_q[c].push_back(int'(x[c*DW +: DW]));
          idx_m[c]++;
        end
        if (cfg_valid && int'(cfg_ch) == c) begin
          ratio_m[c] = (cfg_ratio == 0) ? 1 : int'(cfg_ratio);
          idx_m[c]   = 0;
        end
      end
      if (y_valid && y_ready) begin
        if (exp_q[y_ch].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got ch %0d data %0d expected no sample", y_ch, y);
        end else begin
          chk("sb_data", int'(y), exp_q[y_ch].pop_front());
        end
        got_q.push_back(int'(y_ch) * 65536 + int'(y));
      end
    end
    @(posedge clk);
    #1;
    if (hv) begin
      chk("stall_vld", int'(y_valid), 1);
      chk("stall_y", int'(y), int'(hy));
      chk("stall_ych", int'(y_ch), int'(hch));
    end
    for (int c = 0; c < N; c++) begin
      low_run[c] = x_ready[c] ? 0 : low_run[c] + 1;
      if (low_run[c] > max_low) max_low = low_run[c];
    end
  endtask

  task automatic idle();
    x_valid   = '0;
    cfg_valid = 1'b0;
    y_ready   = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < N; c++) low_run[c] = 0;
    max_low = 0;
  endtask

  task automatic send(input int ch, input int val, input bit cfg_en, input int m);
    int n;
    n = 0;
    x_valid[ch]        = 1'b1;
    x[ch*DW +: DW]     = DW'(val);
    while (!x_ready[ch] && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ch %0d x_ready low %0d cycles, required high", ch, n);
    end
    cfg_valid = cfg_en;
    cfg_ch    = CW'(ch);
    cfg_ratio = RW'(m);
    tick();
    cfg_valid   = 1'b0;
    x_valid[ch] = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (16) tick();
    for (int c = 0; c < N; c++) chk("drain_empty", exp_q[c].size(), 0);
  endtask

  initial begin
    int breaks;
    int exp5[4];
    rst = 1'b0; cfg_ch = '0; cfg_ratio = '0; x = '0;
    idle();
    for (int c = 0; c < N; c++) begin ratio_m[c] = 1; idx_m[c] = 0; low_run[c] = 0; end
    max_low = 0;

    t1[0] = '{1, 1, 0, 0, 0};
    t1[1] = '{1, 2, 1, 1, 1};
    t1[2] = '{1, 2, 0, 0, 0};
    t1[3] = '{1, 3, 1, 1, 2};
    t1[4] = '{1, 3, 0, 0, 0};
    t1[5] = '{0, 0, 1, 1, 3};
    t1[6] = '{0, 0, 1, 0, 0};

    // Reset state
    do_reset();
    chk("rst_yvalid", int'(y_valid), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_ych", int'(y_ch), 0);
    chk("rst_xready", int'(x_ready), 15);

    // Single channel pass-through, cycle exact
    for (int r = 0; r < 7; r++) begin
      x_valid[0] = t1[r].xv[0];
      x[DW-1:0]  = DW'(t1[r].xd);
      tick();
      chk("t1_xready0", int'(x_ready[0]), t1[r].exp_rdy);
      chk("t1_yvalid", int'(y_valid), t1[r].exp_yv);
      if (t1[r].exp_yv != 0) begin
        chk("t1_y", int'(y), t1[r].exp_y);
        chk("t1_ych", int'(y_ch), 0);
      end
    end

    // Decimate by 3 on ch1
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_ratio = 5'd3;
    tick();
    cfg_valid = 1'b0;
    got_q.delete();
    for (int v = 10; v <= 18; v++) send(1, v, 1'b0, 0);
    drain();
    chk("m3_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("m3_s0", got_q[0], 65536 + 10);
      chk("m3_s1", got_q[1], 65536 + 13);
      chk("m3_s2", got_q[2], 65536 + 16);
    end

    // All channels busy: strict rotation, bounded starvation
    do_reset();
    got_q.delete();
    x_valid = '1;
    repeat (40) begin
      x = {$urandom, $urandom};
      tick();
    end
    chk("rr_starve_ok", int'(max_low <= 4), 1);
    chk("rr_enough", int'(got_q.size() >= 30), 1);
    breaks = 0;
    if (got_q.size() > 0 && (got_q[0] >> 16) != 0) breaks++;
    for (int k = 1; k < got_q.size(); k++)
      if ((got_q[k] >> 16) != (((got_q[k-1] >> 16) + 1) % N)) breaks++;
    chk("rr_order_breaks", breaks, 0);

    // Back-pressure under full load
    y_ready = 1'b0;
    repeat (10) begin
      x = {$urandom, $urandom};
      tick();
    end
    chk("bp_xready", int'(x_ready), 0);
    chk("bp_yvalid", int'(y_valid), 1);
    y_ready = 1'b1;
    repeat (10) begin
      x = {$urandom, $urandom};
      tick();
    end
    drain();

    // cfg write coincident with transfers
    do_reset();
    got_q.delete();
    send(2, 100, 1'b1, 4);
    for (int v = 101; v <= 105; v++) send(2, v, 1'b0, 0);
    send(2, 106, 1'b1, 4);
    send(2, 107, 1'b0, 0);
    drain();
    exp5 = '{100, 101, 105, 107};
    chk("cfg_count", got_q.size(), 4);
    if (got_q.size() == 4)
      for (int k = 0; k < 4; k++) chk("cfg_sample", got_q[k], 2 * 65536 + exp5[k]);

    // Reset mid-stream
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_ratio = 5'd3;
    tick();
    cfg_valid = 1'b0;
    x_valid = '1;
    y_ready = 1'b0;
    repeat (5) tick();
    chk("mid_pre_yvalid", int'(y_valid), 1);
    rst = 1'b1;
    x_valid = '0;
    tick();
    rst = 1'b0;
    chk("mid_yvalid", int'(y_valid), 0);
    chk("mid_xready", int'(x_ready), 15);
    y_ready = 1'b1;
    got_q.delete();
    for (int v = 1; v <= 3; v++) send(1, 200 + v, 1'b0, 0);
    drain();
    chk("mid_ratio1_count", got_q.size(), 3);

    // Random traffic with occasional reconfiguration
    do_reset();
    for (int c = 0; c < 600; c++) begin
      x_valid   = N'($urandom);
      x         = {$urandom, $urandom};
      y_ready   = ($urandom_range(0, 9) < 7);
      cfg_valid = ($urandom_range(0, 19) == 0);
      cfg_ch    = CW'($urandom);
      cfg_ratio = RW'($urandom_range(0, 16));
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
